// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module : seven_seg_pkg
// Brief  : Segment pattern constants, snapshot type and BCD decode function
//          shared by the seven-segment scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_OVERFLOW = 4'b1111;

    typedef struct packed {
        logic [3:0][3:0] digits;
        logic            blank_lz;
    } snapshot_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:         seg = SEG_0;
            4'd1:         seg = SEG_1;
            4'd2:         seg = SEG_2;
            4'd3:         seg = SEG_3;
            4'd4:         seg = SEG_4;
            4'd5:         seg = SEG_5;
            4'd6:         seg = SEG_6;
            4'd7:         seg = SEG_7;
            4'd8:         seg = SEG_8;
            4'd9:         seg = SEG_9;
            BCD_OVERFLOW: seg = SEG_DASH;
            default:      seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// ============================================================================
// Module : seven_seg_decoder
// Brief  : Combinational BCD-to-segment decoder with forced-blank input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_value);
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// Module : seven_seg_scanner
// Brief  : Time-multiplexed 4-digit seven-segment driver with per-scan input
//          snapshot and leading-zero blanking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic       BlankLZ,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] An
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    snapshot_t        snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q;
    logic [6:0]       w_dec_seg;
    logic [3:0]       w_lead_zero;
    logic             w_terminal;
    logic             w_blank;

    // w_lead_zero[k]: digit k and every digit above it are zero
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lead_zero
            if (k == 3) begin : g_top
                assign w_lead_zero[k] = (snap_q.digits[k] == 4'd0);
            end else begin : g_lower
                assign w_lead_zero[k] = (snap_q.digits[k] == 4'd0) && w_lead_zero[k+1];
            end
        end
    endgenerate

    always_comb begin
        w_terminal = (cnt_q == C_CNT_LAST);
        cnt_d      = w_terminal ? '0 : cnt_q + CNT_W'(1);
        idx_d      = w_terminal ? idx_q + 2'd1 : idx_q;

        snap_d = snap_q;
        if (cnt_q == '0 && idx_q == 2'd0) begin
            snap_d.digits   = {BCD3, BCD2, BCD1, BCD0};
            snap_d.blank_lz = BlankLZ;
        end

        w_blank = snap_q.blank_lz && (idx_q != 2'd0) && w_lead_zero[idx_q];
        an_d    = ~(4'b0001 << idx_q);
    end

    seven_seg_decoder u_decoder (
        .i_value (snap_q.digits[idx_q]),
        .i_blank (w_blank),
        .o_seg   (w_dec_seg)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= w_dec_seg;
        end
    end

    assign An  = an_q;
    assign Seg = seg_q;
    assign Dp  = 1'b1;

endmodule

`default_nettype wire
